// File: rtl/mouse_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : mouse_tracker
//  Description : PS/2 mouse receiver. Synchronizes the raw PS/2 lines,
//                deframes 11-bit serial frames, assembles 3-byte movement
//                packets and tracks a clamped cursor position and button
//                levels.
//                Optional feature: define MOUSE_PARITY_CHECK_EN to reject
//                bytes whose data+parity bits do not hold odd parity.
//  Revision    : 1.0 - initial release
// ============================================================================
module mouse_tracker #(
    parameter int X_MAX          = 319,
    parameter int Y_MAX          = 239,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] mouse_x,
    output logic [15:0] mouse_y,
    output logic        left_click,
    output logic        right_click,
    output logic        data_ready
);

    localparam int                 c_TO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_WIDTH-1:0] c_TO_LAST = c_TO_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic signed [17:0] c_X_MAX_S  = 18'(X_MAX);
    localparam logic signed [17:0] c_Y_MAX_S  = 18'(Y_MAX);
    localparam logic [15:0]        c_X_MAX    = 16'(X_MAX);
    localparam logic [15:0]        c_Y_MAX    = 16'(Y_MAX);
    localparam logic [15:0]        c_X_RST    = 16'((X_MAX + 1) / 2);
    localparam logic [15:0]        c_Y_RST    = 16'((Y_MAX + 1) / 2);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // Synchronizer and edge detector
    logic r_clk_s1, r_clk_s2, r_clk_prev;
    logic r_data_s1, r_data_s2;
    logic w_fall;

    // Frame deserializer
    state_t                r_state;
    state_t                w_state_nxt;
    logic [2:0]            r_bit_cnt;
    logic [7:0]            r_shift;
    logic                  r_parity;
    logic [c_TO_WIDTH-1:0] r_to_cnt;
    logic                  w_timeout;
    logic                  w_byte_done;
    logic                  w_byte_ok;
    logic                  w_parity_ok;

    // Packet assembly
    logic [1:0] r_idx;
    logic       r_left_b, r_right_b;
    logic       r_x_sign, r_y_sign;
    logic       r_x_ovf, r_y_ovf;
    logic [7:0] r_byte1;
    logic       w_pkt_done;

    // Position arithmetic
    logic signed [17:0] w_dx, w_dy;
    logic signed [17:0] w_new_x, w_new_y;
    logic [15:0]        w_x_clamped, w_y_clamped;

    // Two-flop synchronizers plus one history flop on the clock line;
    // idle PS/2 lines are high, so everything resets to 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_data_s1  <= 1'b1;
            r_data_s2  <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_data_s1  <= ps2_data;
            r_data_s2  <= r_data_s1;
        end
    end

    // The device changes data while its clock is high, so sample on the fall
    assign w_fall = r_clk_prev & ~r_clk_s2;

    // A stalled device leaves us mid-frame; count idle cycles to recover
    assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_to_cnt == c_TO_LAST);

    // Inactivity counter, only running while a frame is in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if ((r_state == S_IDLE) || w_fall || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Frame FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE:   if (!r_data_s2) w_state_nxt = S_DATA;
                S_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
                S_PARITY: w_state_nxt = S_STOP;
                S_STOP:   w_state_nxt = S_IDLE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Bit counter, LSB-first data shifter and parity capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
            r_parity  <= 1'b0;
        end else if (w_timeout) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE: begin
                    r_bit_cnt <= 3'd0;
                end
                S_DATA: begin
                    r_shift   <= {r_data_s2, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                S_PARITY: begin
                    r_parity <= r_data_s2;
                end
                default: ;
            endcase
        end
    end

`ifdef MOUSE_PARITY_CHECK_EN
    // PS/2 uses odd parity across the eight data bits and the parity bit
    assign w_parity_ok = ^{r_parity, r_shift};
`else
    // Parity is captured for completeness but does not gate acceptance
    logic w_unused_parity;
    assign w_parity_ok     = 1'b1;
    assign w_unused_parity = r_parity;
`endif

    assign w_byte_done = w_fall && (r_state == S_STOP);
    assign w_byte_ok   = w_byte_done && r_data_s2 && w_parity_ok;
    assign w_pkt_done  = w_byte_ok && (r_idx == 2'd2);

    // Packet assembler: bit3 of byte0 is always 1, which lets us resync
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx     <= 2'd0;
            r_left_b  <= 1'b0;
            r_right_b <= 1'b0;
            r_x_sign  <= 1'b0;
            r_y_sign  <= 1'b0;
            r_x_ovf   <= 1'b0;
            r_y_ovf   <= 1'b0;
            r_byte1   <= 8'd0;
        end else if (w_timeout) begin
            r_idx <= 2'd0;
        end else if (w_byte_done) begin
            if (!w_byte_ok) begin
                r_idx <= 2'd0;
            end else begin
                case (r_idx)
                    2'd0: begin
                        if (r_shift[3]) begin
                            r_left_b  <= r_shift[0];
                            r_right_b <= r_shift[1];
                            r_x_sign  <= r_shift[4];
                            r_y_sign  <= r_shift[5];
                            r_x_ovf   <= r_shift[6];
                            r_y_ovf   <= r_shift[7];
                            r_idx     <= 2'd1;
                        end
                    end
                    2'd1: begin
                        r_byte1 <= r_shift;
                        r_idx   <= 2'd2;
                    end
                    default: begin
                        r_idx <= 2'd0;
                    end
                endcase
            end
        end
    end

    // 9-bit deltas sign-extended to 18 bits; PS/2 Y grows upward, screen
    // rows grow downward, hence the subtraction
    always_comb begin
        w_dx    = {{9{r_x_sign}}, r_x_sign, r_byte1};
        w_dy    = {{9{r_y_sign}}, r_y_sign, r_shift};
        w_new_x = $signed({2'b00, mouse_x}) + w_dx;
        w_new_y = $signed({2'b00, mouse_y}) - w_dy;

        if (w_new_x < 18'sd0) begin
            w_x_clamped = 16'd0;
        end else if (w_new_x > c_X_MAX_S) begin
            w_x_clamped = c_X_MAX;
        end else begin
            w_x_clamped = w_new_x[15:0];
        end

        if (w_new_y < 18'sd0) begin
            w_y_clamped = 16'd0;
        end else if (w_new_y > c_Y_MAX_S) begin
            w_y_clamped = c_Y_MAX;
        end else begin
            w_y_clamped = w_new_y[15:0];
        end
    end

    // Apply a completed packet; an axis flagged as overflowed keeps its value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mouse_x     <= c_X_RST;
            mouse_y     <= c_Y_RST;
            left_click  <= 1'b0;
            right_click <= 1'b0;
            data_ready  <= 1'b0;
        end else begin
            data_ready <= 1'b0;
            if (w_pkt_done) begin
                if (!r_x_ovf) mouse_x <= w_x_clamped;
                if (!r_y_ovf) mouse_y <= w_y_clamped;
                left_click  <= r_left_b;
                right_click <= r_right_b;
                data_ready  <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
